// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single 64-bit memory, one access per cycle.
// Optional fetch starvation guard enabled by defining STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    input  logic [7:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [63:0]       d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [63:0]       m_wdata,
    output logic [7:0]        m_be,
    input  logic [63:0]       m_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_t;

    state_t state;
    logic   ia2_q;
    logic   dwe_q;
    logic   force_i;

    if (STARVE_MAX < 1) begin : g_cfg_check
        $error("mem_arbiter: STARVE_MAX must be at least 1");
    end

`ifdef STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign force_i = i_req && (starve_cnt == CNT_W'(STARVE_MAX));

    // Counts data wins that happened while a fetch was waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (i_gnt || !i_req) begin
            starve_cnt <= '0;
        end else if (d_gnt && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign force_i = 1'b0;
`endif

    // Grant and memory command are same-cycle so accesses can issue back-to-back.
    always_comb begin
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        if (!rst) begin
            if (d_req && !force_i) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
        if (d_gnt) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_be    = d_be;
        end else if (i_gnt) begin
            m_en   = 1'b1;
            m_addr = i_addr;
        end
    end

    // Responses are gated by rst so a reset right after a grant cancels it.
    always_comb begin
        i_rvalid = !rst && (state == RESP_I);
        d_rvalid = !rst && (state == RESP_D);
        i_rdata  = '0;
        d_rdata  = '0;
        if (i_rvalid) begin
            i_rdata = ia2_q ? m_rdata[63:32] : m_rdata[31:0];
        end
        if (d_rvalid && !dwe_q) begin
            d_rdata = m_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ia2_q <= 1'b0;
            dwe_q <= 1'b0;
        end else begin
            if (d_gnt) begin
                state <= RESP_D;
            end else if (i_gnt) begin
                state <= RESP_I;
            end else begin
                state <= IDLE;
            end
            if (i_gnt) begin
                ia2_q <= i_addr[2];
            end
            if (d_gnt) begin
                dwe_q <= d_we;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, conflict, store, starvation, reset and idle cases.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic [7:0]        d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [63:0]       d_rdata;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [63:0]       m_wdata;
    logic [7:0]        m_be;
    logic [63:0]       m_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks happen mid-cycle.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; m_rdata = '0;
        next();
        // Requests during reset must not be granted
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h104; m_rdata = 64'hFFFF_0000_FFFF_0000;
        settle();
        chk("rst_gnts", {62'd0, i_gnt, d_gnt}, 64'd0);
        chk("rst_mem", {31'd0, m_en, m_we, m_addr}, 64'd0);
        chk("rst_rvalid", {i_rvalid, d_rvalid, i_rdata, 30'd0}, 64'd0);
        chk("rst_drdata", d_rdata, 64'd0);
        next();

        // Single fetch, arbitrated in the cycle rst deasserts
        rst = 1'b0; d_req = 1'b0; i_req = 1'b1; i_addr = 32'h104;
        settle();
        chk("fetch_gnt", {62'd0, i_gnt, d_gnt}, 64'b10);
        chk("fetch_mem", {30'd0, m_en, m_we, m_addr}, {30'd0, 2'b10, 32'h104});
        chk("fetch_mbe_wdata", {m_be, m_wdata[55:0]}, 64'd0);
        chk("fetch_no_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
        next();
        i_req = 1'b0; m_rdata = 64'h1122_3344_AABB_CCDD;
        settle();
        chk("fetch_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'b10);
        chk("fetch_rdata", {32'd0, i_rdata}, 64'h1122_3344);
        chk("fetch_idle_mem", {63'd0, m_en}, 64'd0);
        next();
        settle();
        chk("fetch_pulse", {62'd0, i_rvalid, d_rvalid}, 64'd0);
        chk("fetch_rdata_zero", {32'd0, i_rdata}, 64'd0);

        // Conflict: data wins first, fetch follows
        next();
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        settle();
        chk("conf_t0_gnt", {62'd0, i_gnt, d_gnt}, 64'b01);
        chk("conf_t0_maddr", {31'd0, m_we, m_addr}, 64'h200);
        next();
        d_req = 1'b0; m_rdata = 64'h0123_4567_89AB_CDEF;
        settle();
        chk("conf_t1_gnt", {62'd0, i_gnt, d_gnt}, 64'b10);
        chk("conf_t1_maddr", {32'd0, m_addr}, 64'h10);
        chk("conf_t1_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'b01);
        chk("conf_t1_drdata", d_rdata, 64'h0123_4567_89AB_CDEF);
        next();
        i_req = 1'b0; m_rdata = 64'hCAFE_F00D_5555_7777;
        settle();
        chk("conf_t2_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'b10);
        chk("conf_t2_irdata", {32'd0, i_rdata}, 64'h5555_7777);
        chk("conf_t2_drdata", d_rdata, 64'd0);

        // Store: command same cycle, write ack next cycle with zero data
        next();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h308; d_be = 8'h0F; d_wdata = 64'hDEAD_BEEF;
        settle();
        chk("st_gnt", {62'd0, i_gnt, d_gnt}, 64'b01);
        chk("st_mem", {22'd0, m_en, m_we, m_be, m_addr}, {22'd0, 2'b11, 8'h0F, 32'h308});
        chk("st_wdata", m_wdata, 64'hDEAD_BEEF);
        next();
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_wdata = '0; m_rdata = 64'h9999_8888_7777_6666;
        settle();
        chk("st_ack", {62'd0, i_rvalid, d_rvalid}, 64'b01);
        chk("st_rdata_zero", d_rdata, 64'd0);

        // Starvation: both requests held for 10 cycles
        for (int k = 0; k < 10; k++) begin
            next();
            i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = 32'h80;
            settle();
`ifdef STARVE_GUARD_EN
            chk($sformatf("starve_%0d", k), {62'd0, i_gnt, d_gnt},
                (k % 5 == 4) ? 64'b10 : 64'b01);
`else
            chk($sformatf("starve_%0d", k), {62'd0, i_gnt, d_gnt}, 64'b01);
`endif
        end
        next();
        i_req = 1'b0; d_req = 1'b0;
        next();

        // Reset in the cycle after a grant cancels the response
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; m_rdata = 64'h1;
        settle();
        chk("rstmid_gnt", {62'd0, i_gnt, d_gnt}, 64'b01);
        next();
        rst = 1'b1; d_req = 1'b0;
        settle();
        chk("rstmid_t1", {62'd0, i_rvalid, d_rvalid}, 64'd0);
        chk("rstmid_t1_rdata", d_rdata, 64'd0);
        next();
        rst = 1'b0;
        settle();
        chk("rstmid_t2", {61'd0, i_rvalid, d_rvalid, m_en}, 64'd0);
        next();
        settle();
        chk("rstmid_t3", {61'd0, i_rvalid, d_rvalid, m_en}, 64'd0);

        // Idle for 10 cycles
        m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 10; k++) begin
            next();
            settle();
            chk($sformatf("idle_%0d", k), {59'd0, m_en, i_gnt, d_gnt, i_rvalid, d_rvalid}, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width on all ports.
REQ-002 Parameter STARVE_MAX, default 4: consecutive data grants allowed while i_req is pending (used only with STARVE_GUARD_EN).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_req  input  1  instruction-fetch read request; held with i_addr until i_gnt.
REQ-006 i_addr  input  ADDR_W  fetch byte address, 4-byte aligned.
REQ-007 i_gnt  output  1  fetch request accepted this cycle.
REQ-008 i_rvalid  output  1  fetch data valid, one-cycle pulse.
REQ-009 i_rdata  output  32  fetched instruction word.
REQ-010 d_req  input  1  data-port request; held with d_we/d_addr/d_wdata/d_be until d_gnt.
REQ-011 d_we  input  1  1 = write, 0 = read.
REQ-012 d_addr  input  ADDR_W  data byte address, 8-byte aligned.
REQ-013 d_wdata  input  64  store data.
REQ-014 d_be  input  8  store byte enables.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  data access complete (read data or write ack), one-cycle pulse.
REQ-017 d_rdata  output  64  load data.
REQ-018 m_en, m_we  output  1 each  memory access enable and write enable.
REQ-019 m_addr  output  ADDR_W; m_wdata  output  64; m_be  output  8  memory command fields.
REQ-020 m_rdata  input  64  memory read data, valid one cycle after m_en with m_we=0.

Function
REQ-021 The FSM SHALL have states IDLE, RESP_I, RESP_D, recording the owner of the access issued in the previous cycle.
REQ-022 Arbitration SHALL occur in every state (back-to-back, one access per cycle); d_req SHALL win over i_req unless the starvation guard forces I.
REQ-023 i_gnt and d_gnt SHALL be combinational from requests and state, at most one high per cycle, both 0 while rst=1.
REQ-024 On a grant, m_en=1 and m_addr/m_we/m_wdata/m_be SHALL carry the winner's fields in the same cycle; I grants drive m_we=0, m_be=0, m_wdata=0.
REQ-025 With no grant, m_en=0, m_we=0, all other m_* outputs 0.
REQ-026 Next state: RESP_D if d_gnt, RESP_I if i_gnt, else IDLE.
REQ-027 In RESP_I, i_rvalid=1 and i_rdata = m_rdata[63:32] if the registered i_addr[2]=1, else m_rdata[31:0].
REQ-028 In RESP_D, d_rvalid=1; d_rdata = m_rdata for reads, 0 for writes.
REQ-029 A port's rdata SHALL be 0 whenever its rvalid is 0.
REQ-030 Grant-to-rvalid latency SHALL be exactly 1 cycle for both ports.

Reset
REQ-031 During rst: state IDLE, starvation counter 0, all gnt/rvalid/m_en/m_we outputs 0, all data outputs 0.
REQ-032 rst asserted in the cycle after a grant SHALL cancel that response: no rvalid is produced for it, ever.
REQ-033 Requests present in the cycle rst deasserts SHALL be arbitrated normally in that cycle.

Configuration
REQ-034 Macro STARVE_GUARD_EN defined: a counter increments on each d_gnt while i_req=1, clears on i_gnt or when i_req=0; when it equals STARVE_MAX and i_req=1, the I port SHALL win regardless of d_req.
REQ-035 Macro STARVE_GUARD_EN undefined: no counter is built; d_req strictly wins every conflict.

Verification
REQ-036 Single fetch: i_req, i_addr=0x104, m_rdata=0x11223344_AABBCCDD -> i_gnt at T, i_rvalid at T+1, i_rdata=0x11223344.
REQ-037 Conflict: i_req and d_req (read 0x200) both high -> d_gnt at T, i_gnt at T+1, d_rvalid at T+1, i_rvalid at T+2.
REQ-038 Store: d_we=1, d_be=0x0F, d_wdata=0xDEADBEEF -> m_en=1, m_we=1, m_be=0x0F same cycle; d_rvalid next cycle with d_rdata=0.
REQ-039 Starvation with STARVE_GUARD_EN, STARVE_MAX=4: d_req and i_req held high -> 4 d_gnt, then 1 i_gnt, repeating; without macro -> i_gnt never asserts.
REQ-040 Reset mid-access: d_gnt at T, rst=1 at T+1 -> d_rvalid=0 at T+1 and T+2, state IDLE after release.
REQ-041 Idle: no requests for 10 cycles -> m_en, gnts, rvalids all 0; state remains IDLE.
